fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the RV32C core. It sits directly upstream of the decoder and replaces the combinational program-memory lookup. It fetches aligned 32-bit words from a synchronous instruction memory with a fixed one-cycle read latency, splits each word into two 16-bit compressed instructions, and buffers them in a small halfword queue. It presents them to the decoder with a valid/ready handshake and accepts PC redirects from the branch/jump logic.

## Interface
- DEPTH, 4: halfword queue entries; power of two, >= 4.
- RESET_PC, 32'd0: PC after reset; bit 0 ignored.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  read request to instruction memory this cycle.
- mem_addr  out  32  word-aligned read address; bits [1:0] always 0.
- mem_rdata  in  32  read data; valid in the cycle after mem_req=1. Bits [15:0] hold the halfword at mem_addr; bits [31:16] hold the halfword at mem_addr+2.
- redirect  in  1  taken jump/branch; flush and refetch.
- redirect_pc  in  32  new PC; bit 0 ignored.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst  out  16  instruction at the queue head.
- inst_pc  out  32  PC of inst; bit 0 always 0.
- inst_ready  in  1  decoder consumes inst this cycle.

## Operation
- State:
  - fetch_pc: next word address, [1:0]=0.
  - head_pc: PC of the queue head.
  - Queue: DEPTH x 16 entries with rd/wr pointers and a count of 0..DEPTH.
  - pending: a request was issued last cycle.
  - skip: drop the low halfword of the next response.
- Reset:
  - fetch_pc={RESET_PC[31:2],2'b00}.
  - head_pc={RESET_PC[31:1],1'b0}.
  - skip=RESET_PC[1].
  - count=0, pointers=0, pending=0.
  - Outputs: inst_valid=0, mem_req=0, inst_pc=head_pc.
- Request: mem_req = !reset && !redirect && (count + 2*pending <= DEPTH-2). mem_addr=fetch_pc. On issue, fetch_pc += 4 (wraps modulo 2^32) and pending<=1; otherwise pending<=0.
- Response (pending=1, no redirect):
  - skip=0: push mem_rdata[15:0] then [31:16], i.e. two entries.
  - skip=1: push only [31:16] and clear skip.
  - The space check guarantees there is room; overflow is impossible.
- Output: inst_valid = (count!=0); inst = queue[rd]; inst_pc = head_pc. inst and inst_pc are register/memory reads, with no combinational path from inputs.
- Pop: on inst_valid && inst_ready, advance rd and set head_pc += 2. Asserting inst_ready while inst_valid=0 has no effect.
- Push and pop in the same cycle are both honoured: count += pushed - popped. This holds even when count=DEPTH, because a push then cannot occur by construction.
- Redirect (highest priority, overrides push, pop and request in that cycle):
  - Clear count and pointers.
  - Discard any response arriving this cycle; set pending<=0.
  - fetch_pc={redirect_pc[31:2],2'b00}; head_pc={redirect_pc[31:1],1'b0}; skip=redirect_pc[1].
  - A pop handshake in the redirect cycle is ignored; the decoder's jump consumed that instruction.
- reset takes priority over redirect. Reset in mid-stream drops any in-flight response.
- Every instruction is 16-bit (RV32C only); no 32-bit instruction assembly.

## Timing
- Cold start: reset released before cycle 0.
  - Cycle 0: mem_req=1, addr=RESET_PC word.
  - Cycle 1: data pushed.
  - Cycle 2: inst_valid=1.
  - Request-to-valid latency is 2 cycles.
- Redirect at cycle t:
  - t+1: inst_valid=0, mem_req=1.
  - t+2: push.
  - t+3: inst_valid=1 with inst_pc=redirect_pc.
- Steady state with inst_ready=1 and DEPTH=4: requests alternate with gaps; sustained throughput is at least 1 instruction/cycle once primed.
- All state updates occur on posedge clock. mem_req is combinational from registered state plus redirect/reset.

## Test plan
- Reset with RESET_PC=0; memory word0=32'hBBBB_AAAA, word4=32'hDDDD_CCCC; inst_ready=1 -> instructions AAAA@0, BBBB@2, CCCC@4, DDDD@6, with the first valid in cycle 2 and no gaps afterwards.
- inst_ready=0 for 10 cycles -> count saturates at 4, mem_req stays 0 once 4 entries are held or pending, inst holds AAAA@0; releasing inst_ready resumes in order with no loss or duplication.
- Redirect to 32'h0000_0106 while a response is in flight -> the stale response is dropped; the next inst is mem[0x104][31:16] with inst_pc=0x106, arriving at t+3.
- Redirect to 0x200 in the same cycle as a pop and a response -> neither the pop nor the push takes effect; inst_valid=0 at t+1 and inst_pc=0x200 at t+3.
- fetch_pc at 32'hFFFF_FFFC -> the next mem_addr is 0x0000_0000 and inst_pc wraps 0xFFFF_FFFE -> 0x0000_0000.
- Assert reset for one cycle mid-stream with RESET_PC=2 -> inst_valid=0 the next cycle, the in-flight data is discarded, and the first inst is mem[0][31:16]@2.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the RV32C core: fetches aligned words, splits them into
// halfwords, and queues them for the decoder behind a valid/ready handshake.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned FillW = CntW + 1;

  logic [15:0]      queue [DEPTH];
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW-1:0]  wr_ptr;
  logic [CntW-1:0]  count;
  logic [CntW-1:0]  n_push;
  logic [FillW-1:0] fill;
  logic [31:0]      fetch_pc;
  logic [31:0]      head_pc;
  logic             pending;
  logic             skip;
  logic             push;
  logic             pop;

  assign inst_valid = (count != '0);
  assign inst       = queue[rd_ptr];
  assign inst_pc    = head_pc;
  assign mem_addr   = fetch_pc;

  always_comb begin
    // An in-flight request reserves two slots so its response can never overflow.
    fill    = {1'b0, count} + (pending ? FillW'(2) : FillW'(0));
    mem_req = !reset && !redirect && (fill <= FillW'(DEPTH - 2));
    push    = pending && !redirect && !reset;
    pop     = inst_valid && inst_ready && !redirect;
    n_push  = '0;
    if (push) begin
      n_push = skip ? CntW'(1) : CntW'(2);
    end
  end

  // Storage is not reset; count and pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      if (skip) begin
        queue[wr_ptr] <= mem_rdata[31:16];
      end else begin
        queue[wr_ptr]              <= mem_rdata[15:0];
        queue[wr_ptr + PtrW'(1)]   <= mem_rdata[31:16];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      head_pc  <= {RESET_PC[31:1], 1'b0};
      skip     <= RESET_PC[1];
      pending  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'd3;
      head_pc  <= redirect_pc & ~32'd1;
      skip     <= redirect_pc[1];
      pending  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      pending <= mem_req;
      if (mem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        skip   <= 1'b0;
        wr_ptr <= wr_ptr + (skip ? PtrW'(1) : PtrW'(2));
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PtrW'(1);
        head_pc <= head_pc + 32'd2;
      end
      count <= count + n_push - CntW'(pop);
    end
  end

endmodule
